multdiv_sequencer: RTL and testbench
====================================

Name: multdiv_sequencer

Overview:
- Multi-cycle signed multiply/divide unit with its own controller. It sits beside the ALU in the execute stage.
- The pipeline control issues a one-cycle start pulse and stalls until the result-ready pulse arrives.
- A single shared shift/add-subtract datapath serves both operations. An internal FSM and iteration counter sequence it.
- Operands are converted to magnitudes on entry. Sign is corrected on exit, so the processor sees two's-complement results.

Parameters:
- WIDTH, 32, operand/result width in bits; iteration count equals WIDTH.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low; sampled on rising edge of clock.
- ctrl_MULT  input  1  one-cycle start pulse for multiply.
- ctrl_DIV  input  1  one-cycle start pulse for divide.
- data_operandA  input  WIDTH  multiplicand/dividend; sampled only on a start edge.
- data_operandB  input  WIDTH  multiplier/divisor; sampled only on a start edge.
- data_result  output  WIDTH  low WIDTH bits of product, or quotient.
- data_exception  output  1  overflow or divide-by-zero flag for the completed op.
- data_resultRDY  output  1  one-cycle pulse marking result valid.
- busy  output  1  high from the start edge until the resultRDY cycle, inclusive.

Behaviour:
- Reset (reset==0 at an edge):
  - State goes to IDLE, counter clears.
  - data_result=0, data_exception=0, data_resultRDY=0, busy=0.
  - Reset overrides everything, including an op in flight and a simultaneous start.
- FSM states: IDLE, MUL, DIV, FIX, DONE.
- Start from IDLE or DONE (edge E0):
  - Latch |A|, |B|, op type and result sign (A[msb]^B[msb]).
  - Record zero-divisor and INT_MIN/-1 conditions.
  - Clear the counter; go to MUL or DIV.
  - ctrl_MULT and ctrl_DIV high together: multiply wins, divide is ignored.
- MUL: radix-2 shift-add on magnitudes into a 2*WIDTH product register. One bit per cycle, WIDTH cycles, then FIX.
- DIV: restoring division on magnitudes, one quotient bit per cycle, WIDTH cycles, then FIX.
- FIX (1 cycle): negate the result if the sign bit is set, then compute the exception.
  - Multiply: exception=1 iff the signed 2*WIDTH product is not representable in WIDTH bits, i.e. the upper WIDTH+1 bits are not all equal. data_result is still the low WIDTH bits.
  - Divide by zero: data_result=0, exception=1.
  - INT_MIN / -1: data_result=0x80000000, exception=1.
  - Other divides: quotient truncated toward zero, remainder discarded, exception=0.
- DONE (1 cycle):
  - data_resultRDY=1; result and exception are valid.
  - Next state is IDLE, unless a start is present that cycle.
- Latency: resultRDY is high exactly WIDTH+2 cycles after E0 (34 for WIDTH=32). The latency is identical for all operand values, including the exception cases.
- Output hold: data_result and data_exception hold their values after DONE until the FIX of the next operation completes. Intermediate iteration values never appear on data_result.
- Start while busy (MUL/DIV/FIX): the in-flight op is abandoned and no resultRDY is issued for it. New operands are latched and the counter restarts, with the same latency from the new edge.
- The counter counts 0..WIDTH-1 and does not wrap. Reaching WIDTH-1 forces the exit to FIX.
- Negating INT_MIN in the magnitude stage yields 0x80000000 treated as unsigned 2^31. This is correct for both datapaths.
- No start while IDLE: all outputs are static and resultRDY stays 0.

Test Plan:
- MULT, A=7, B=-3 (0xFFFFFFFD), pulse at E0:
  - busy=1 for 35 cycles (E0 through E34).
  - resultRDY only at E0+34.
  - result=0xFFFFFFEB (-21), exception=0.
- MULT, A=0x00010000, B=0x00010000 → result=0x00000000, exception=1. Then A=-1, B=-1 → result=1, exception=0.
- DIV, A=-7, B=2 → result=0xFFFFFFFD (-3), exception=0. Then A=100, B=-10 → -10 (0xFFFFFFF6).
- DIV, A=5, B=0 → result=0, exception=1 at E0+34. Then A=0x80000000, B=-1 → result=0x80000000, exception=1.
- Restart: DIV 100/7 at E0, then MULT 6*7 at E0+10:
  - no resultRDY at E0+34.
  - resultRDY at E0+44 with result=42.
- Reset low at E0+15 during MULT:
  - next cycle all outputs 0 and busy=0.
  - no resultRDY follows.
  - a fresh start after reset returns correct results at +34.

Source files
------------

// File: rtl/multdiv_sequencer_if.sv
// Handshake and data bundle between the execute-stage control and the multiply/divide unit.
// The unit drives the slave side and the pipeline drives the master side.
interface multdiv_sequencer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
        input  data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
        output data_result, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/multdiv_sequencer.sv
// Sequential signed multiply/divide: magnitudes go through one shared shift/add-subtract
// datapath for WIDTH cycles, then the sign and exception are fixed up in a single cycle.
module multdiv_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input logic                 clock,
    input logic                 reset,
    multdiv_sequencer_if.slave  bus
);
    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] IntMin = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {StIdle, StMul, StDiv, StFix, StDone} state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               exc_q, exc_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               op_mul_q, op_mul_d;
    logic               sign_q, sign_d;
    logic               dz_q, dz_d;
    logic               ovf_q, ovf_d;

    logic               start_mul, start_div, cnt_last;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   add_a, add_b, sum;
    logic               add_cin, q_bit;
    logic [2*WIDTH-1:0] full;
    logic [WIDTH:0]     prod_top;

    assign start_mul = bus.ctrl_MULT;
    assign start_div = bus.ctrl_DIV & ~bus.ctrl_MULT;
    assign cnt_last  = (cnt_q == CntW'(WIDTH - 1));

    // INT_MIN maps onto itself, which reads correctly as unsigned 2^(WIDTH-1).
    assign mag_a = bus.data_operandA[WIDTH-1] ? (~bus.data_operandA + WIDTH'(1))
                                              : bus.data_operandA;
    assign mag_b = bus.data_operandB[WIDTH-1] ? (~bus.data_operandB + WIDTH'(1))
                                              : bus.data_operandB;

    // Shared adder: accumulate for multiply, trial-subtract the divisor for divide.
    assign div_shift = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
    always_comb begin
        if (op_mul_q) begin
            add_a   = {2'b00, prod_q[2*WIDTH-1:WIDTH]};
            add_b   = {2'b00, opnd_q & {WIDTH{prod_q[0]}}};
            add_cin = 1'b0;
        end else begin
            add_a   = {1'b0, div_shift};
            add_b   = ~{2'b00, opnd_q};
            add_cin = 1'b1;
        end
    end
    assign sum   = add_a + add_b + {{(WIDTH+1){1'b0}}, add_cin};
    assign q_bit = ~sum[WIDTH+1];

    assign full     = sign_q ? (~prod_q + {{(2*WIDTH-1){1'b0}}, 1'b1}) : prod_q;
    assign prod_top = full[2*WIDTH-1:WIDTH-1];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        exc_d    = exc_q;
        prod_d   = prod_q;
        opnd_d   = opnd_q;
        op_mul_d = op_mul_q;
        sign_d   = sign_q;
        dz_d     = dz_q;
        ovf_d    = ovf_q;

        unique case (state_q)
            StMul: begin
                prod_d = {sum[WIDTH:0], prod_q[WIDTH-1:1]};
                cnt_d  = cnt_q + CntW'(1);
                if (cnt_last) begin
                    state_d = StFix;
                    cnt_d   = '0;
                end
            end
            StDiv: begin
                prod_d = {(q_bit ? sum[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                          prod_q[WIDTH-2:0], q_bit};
                cnt_d  = cnt_q + CntW'(1);
                if (cnt_last) begin
                    state_d = StFix;
                    cnt_d   = '0;
                end
            end
            StFix: begin
                state_d = StDone;
                if (op_mul_q) begin
                    result_d = full[WIDTH-1:0];
                    exc_d    = ~(&prod_top) & (|prod_top);
                end else if (dz_q) begin
                    result_d = '0;
                    exc_d    = 1'b1;
                end else begin
                    result_d = full[WIDTH-1:0];
                    exc_d    = ovf_q;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // A start in any state abandons whatever is in flight.
        if (start_mul | start_div) begin
            state_d  = start_mul ? StMul : StDiv;
            cnt_d    = '0;
            op_mul_d = start_mul;
            sign_d   = bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
            dz_d     = start_div & (bus.data_operandB == '0);
            ovf_d    = start_div & (bus.data_operandA == IntMin) & (&bus.data_operandB);
            opnd_d   = start_mul ? mag_a : mag_b;
            prod_d   = {{WIDTH{1'b0}}, (start_mul ? mag_b : mag_a)};
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            exc_q    <= exc_d;
        end
    end

    always_ff @(posedge clock) begin
        prod_q   <= prod_d;
        opnd_q   <= opnd_d;
        op_mul_q <= op_mul_d;
        sign_q   <= sign_d;
        dz_q     <= dz_d;
        ovf_q    <= ovf_d;
    end

    assign bus.data_result    = result_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = (state_q == StDone);
    assign bus.busy           = (state_q != StIdle) | bus.ctrl_MULT | bus.ctrl_DIV;
endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed bench for multdiv_sequencer: signed products, quotients, exceptions,
// restart while busy and reset mid-operation, sampled on the falling edge.
module tb_multdiv_sequencer;
    localparam int unsigned W = 32;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;

    multdiv_sequencer_if #(.WIDTH(W)) bus ();

    multdiv_sequencer #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Values seen at a falling edge are the ones the next rising edge samples (E_k).
    task automatic do_op(input string tag, input logic m, input logic d,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic ee);
        int          first_rdy;
        int          n_rdy;
        int          n_busy;
        logic [31:0] r;
        logic        e;
        first_rdy = -1;
        n_rdy     = 0;
        n_busy    = 0;
        r         = '0;
        e         = 1'b0;
        @(negedge clock);
        bus.ctrl_MULT     = m;
        bus.ctrl_DIV      = d;
        bus.data_operandA = a;
        bus.data_operandB = b;
        #1 check({tag, ".busy_e0"}, 32'(bus.busy), 32'd1);
        for (int k = 1; k <= 36; k++) begin
            @(negedge clock);
            if (k == 1) begin
                bus.ctrl_MULT     = 1'b0;
                bus.ctrl_DIV      = 1'b0;
                bus.data_operandA = $urandom;
                bus.data_operandB = $urandom;
            end
            n_busy += int'(bus.busy);
            if (bus.data_resultRDY === 1'b1) begin
                n_rdy++;
                if (first_rdy < 0) begin
                    first_rdy = k;
                    r         = bus.data_result;
                    e         = bus.data_exception;
                end
            end
        end
        check({tag, ".latency"}, 32'(first_rdy), 32'd34);
        check({tag, ".rdy_count"}, 32'(n_rdy), 32'd1);
        check({tag, ".busy_cycles"}, 32'(n_busy), 32'd34);
        check({tag, ".result"}, r, er);
        check({tag, ".exception"}, 32'(e), 32'(ee));
        check({tag, ".hold"}, bus.data_result, er);
    endtask

    initial begin
        int          first_rdy;
        int          n_rdy;
        int          n_busy;
        logic        rdy_at34;
        logic [31:0] r;
        logic        e;

        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;

        // Reset state
        repeat (3) @(negedge clock);
        check("reset.result", bus.data_result, 32'h0);
        check("reset.exception", 32'(bus.data_exception), 32'h0);
        check("reset.rdy", 32'(bus.data_resultRDY), 32'h0);
        check("reset.busy", 32'(bus.busy), 32'h0);
        reset = 1'b1;

        // Idle with no start stays quiet
        n_rdy  = 0;
        n_busy = 0;
        repeat (5) begin
            @(negedge clock);
            n_rdy  += int'(bus.data_resultRDY);
            n_busy += int'(bus.busy);
        end
        check("idle.rdy", 32'(n_rdy), 32'd0);
        check("idle.busy", 32'(n_busy), 32'd0);

        do_op("mul_7x-3", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
        do_op("mul_ovf", 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1);
        do_op("mul_-1x-1", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        do_op("mul_wins", 1'b1, 1'b1, 32'hFFFF_FFFC, 32'd5, 32'hFFFF_FFEC, 1'b0);
        do_op("div_-7/2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
        do_op("div_100/-10", 1'b0, 1'b1, 32'd100, 32'hFFFF_FFF6, 32'hFFFF_FFF6, 1'b0);
        do_op("div_by0", 1'b0, 1'b1, 32'd5, 32'd0, 32'h0000_0000, 1'b1);
        do_op("div_intmin", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);

        // Restart: DIV 100/7 at E0, MULT 6*7 at E10
        first_rdy = -1;
        n_rdy     = 0;
        rdy_at34  = 1'b0;
        r         = '0;
        e         = 1'b0;
        @(negedge clock);
        bus.ctrl_DIV      = 1'b1;
        bus.data_operandA = 32'd100;
        bus.data_operandB = 32'd7;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clock);
            if (k == 1 || k == 11) begin
                bus.ctrl_MULT = 1'b0;
                bus.ctrl_DIV  = 1'b0;
            end
            if (k == 10) begin
                bus.ctrl_MULT     = 1'b1;
                bus.data_operandA = 32'd6;
                bus.data_operandB = 32'd7;
            end
            if (k == 34) rdy_at34 = bus.data_resultRDY;
            if (bus.data_resultRDY === 1'b1) begin
                n_rdy++;
                if (first_rdy < 0) begin
                    first_rdy = k;
                    r         = bus.data_result;
                    e         = bus.data_exception;
                end
            end
        end
        check("restart.no_rdy_e34", 32'(rdy_at34), 32'd0);
        check("restart.latency", 32'(first_rdy), 32'd44);
        check("restart.rdy_count", 32'(n_rdy), 32'd1);
        check("restart.result", r, 32'd42);
        check("restart.exception", 32'(e), 32'd0);

        // Reset low at E15 during a multiply
        n_rdy = 0;
        @(negedge clock);
        bus.ctrl_MULT     = 1'b1;
        bus.data_operandA = 32'd123;
        bus.data_operandB = 32'd456;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clock);
            if (k == 1) bus.ctrl_MULT = 1'b0;
            if (k == 15) reset = 1'b0;
            if (k == 16) begin
                check("rst_mid.result", bus.data_result, 32'h0);
                check("rst_mid.exception", 32'(bus.data_exception), 32'h0);
                check("rst_mid.rdy", 32'(bus.data_resultRDY), 32'h0);
                check("rst_mid.busy", 32'(bus.busy), 32'h0);
                reset = 1'b1;
            end
            n_rdy += int'(bus.data_resultRDY);
        end
        check("rst_mid.no_rdy", 32'(n_rdy), 32'd0);

        do_op("post_rst_mul", 1'b1, 1'b0, 32'd123, 32'hFFFF_FE38, 32'hFFFF_24E8, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
